nios_practica_buttons_in: RTL and testbench
===========================================

// Module: nios_practica_buttons_in
// PURPOSE
//  Avalon-MM slave input PIO: the read-side counterpart of the LED output PIO.
//  - Samples WIDTH asynchronous board inputs (push-buttons/switches) and debounces them.
//  - Latches qualifying edges into a sticky capture register and raises a maskable irq to the Nios II.
//  - Sits on the same system interconnect as the LED PIO, with the same 2-bit word address map style.
// PARAMETERS
//  WIDTH            4            number of input bits (1..32)
//  DEBOUNCE_CYCLES  50000        cycles an input must hold a new level before accepted (>=1; 1 ms @ 50 MHz)
//  EDGE_TYPE        1            0 = rising, 1 = falling, 2 = any edge sets edge_capture
//  RESET_LEVEL      {WIDTH{1'b1}} reset value of synchronizer and debounced state (buttons idle high)
// PORTS
//  clk         in   1      system clock; the block's single clock
//  reset_n     in   1      synchronous, active-low reset
//  address     in   2      word address: 0 data, 1 reserved, 2 irq_mask, 3 edge_capture
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data; bits [WIDTH-1:0] used
//  in_port     in   WIDTH  raw asynchronous inputs
//  readdata    out  32     read data, zero-extended above WIDTH
//  irq         out  1      level interrupt = |(edge_capture & irq_mask)
// BEHAVIOUR
//  Reset:
//  - Synchronous: on the first rising clk edge with reset_n=0, sync1/sync2/stable <= RESET_LEVEL.
//  - Debounce counters, irq_mask and edge_capture <= 0, so irq=0.
//  - Reset asserted mid-debounce discards the partial count; no edge is captured.
//  Synchronizer:
//  - 2 flops per bit: sync1 <= in_port, sync2 <= sync1.
//  Debounce, per bit:
//  - if sync2 == stable: cnt <= 0.
//  - else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
//  - else: cnt <= cnt+1.
//  - A glitch shorter than DEBOUNCE_CYCLES sync2 cycles never reaches stable.
//  - Latency: in_port level held from edge t -> stable updates at edge t+1+DEBOUNCE_CYCLES.
//  - Counter width clog2(DEBOUNCE_CYCLES), minimum 1.
//  Edge capture:
//  - Bit i is set on the same edge stable[i] updates, if the direction matches EDGE_TYPE.
//  - Bits are sticky and are cleared only by a write to address 3.
//  - Write to address 3: clear each bit where writedata[i]=1 (W1C).
//  - Set and clear on the same edge: set wins, so the bit stays 1.
//  Register writes:
//  - Write (chipselect & ~write_n) to address 2: irq_mask <= writedata[WIDTH-1:0].
//  - Writes to addresses 0 and 1 are ignored.
//  Reads (combinational, zero wait states, no read side effects):
//  - addr 0 returns stable; addr 1 returns 0; addr 2 returns irq_mask; addr 3 returns edge_capture.
//  irq:
//  - Combinational from registers; follows mask writes and W1C on the following cycle.
// STRUCTURE
//  - Shared package nios_practica_pio_pkg holds the register address localparams (PIO_ADDR_DATA=0,
//    PIO_ADDR_MASK=2, PIO_ADDR_EDGE=3) and edge constants (EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2).
//  - The LED PIO reuses the same package.
//  - Sub-module nios_practica_debounce_bit: synchronizer + counter + stable flop for one bit,
//    with an output pulse on rise/fall. Instantiated WIDTH times in a generate loop.
//  - The top level holds the registers, address decode, read mux and irq.
// TESTING (bench: WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1)
//  1. Hold reset_n=0 for 2 clks with in_port=4'b0000 -> readdata@0 = 4'hF, edge_capture=0, irq=0.
//  2. in_port[0] 1->0 held from edge t -> stable[0]=0 at edge t+5; edge_capture=4'h1;
//     irq stays 0 while mask=0; after writing mask=4'h1 -> irq=1 next cycle.
//  3. in_port[1] low for 3 cycles, then high -> stable unchanged, edge_capture[1]=0 (glitch rejected).
//  4. Write 4'h1 to addr 3 -> edge_capture=0, irq=0; repeat on the exact edge a new bit-0 edge is
//     accepted -> bit stays 1.
//  5. Rising edge on in_port[2] with EDGE_TYPE=1 -> stable[2]=1, edge_capture[2]=0;
//     rerun with EDGE_TYPE=2 -> edge_capture[2]=1.
//  6. Assert reset_n=0 at cycle 2 of a debounce -> stable=4'hF, count discarded, no capture after release.

Source files
------------

// File: rtl/nios_practica_pio_pkg.sv
// Shared definitions for the Nios "practica" PIO peripherals (buttons input
// PIO and LED output PIO).
//  - Word addresses of the PIO register map.
//  - Edge-type selectors for edge capture.
//  - Helpers for the debounce counter width and the edge qualification.
package nios_practica_pio_pkg;

  // Register word addresses
  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  // Edge selectors for the capture register
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Width of a counter that must reach cycles-1; never narrower than 1 bit.
  function automatic int debounce_cnt_w(input int cycles);
    int w;
    w = (cycles > 1) ? $clog2(cycles) : 1;
    return w;
  endfunction

  // True when an accepted transition matches the configured edge type.
  function automatic logic edge_hit(input logic rise, input logic fall,
                                    input int edge_type);
    logic hit;
    case (edge_type)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      default:   hit = rise | fall;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/nios_practica_buttons_in_if.sv
// Avalon-MM slave bus bundle for the buttons input PIO.
//  address    2-bit word address
//  chipselect slave select
//  write_n    active-low write strobe
//  writedata  32-bit write data
//  readdata   32-bit read data (combinational, zero wait states)
//  irq        level interrupt towards the Nios II
interface nios_practica_buttons_in_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/nios_practica_debounce_bit.sv
// One input bit of the buttons PIO: two-flop synchronizer, debounce counter
// and the accepted (stable) level.
//  clk      system clock
//  reset_n  synchronous active-low reset
//  in_bit   raw asynchronous input
//  stable   debounced level
//  rise     high during the cycle whose edge accepts a 0->1 transition
//  fall     high during the cycle whose edge accepts a 1->0 transition
// rise/fall are combinational so the parent can capture the edge on the very
// clock edge that updates stable. They are meaningless while reset_n is low;
// the parent gives reset priority over them.
module nios_practica_debounce_bit
  import nios_practica_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int              CNT_W    = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // sync2 has disagreed with stable for DEBOUNCE_CYCLES consecutive samples
  assign accept = (sync2 != stable) && (cnt == CNT_LAST);
  assign rise   = accept &  sync2;
  assign fall   = accept & ~sync2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1  <= RESET_LEVEL;
      sync2  <= RESET_LEVEL;
      stable <= RESET_LEVEL;
      cnt    <= '0;
    end else begin
      // synchronizer stage
      sync1 <= in_bit;
      sync2 <= sync1;
      // debounce stage: any agreement restarts the run
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/nios_practica_buttons_in.sv
// Buttons/switches input PIO on the Avalon-MM interconnect.
//  clk      system clock
//  reset_n  synchronous active-low reset
//  bus      Avalon-MM slave (address, chipselect, write_n, writedata,
//           readdata, irq)
//  in_port  WIDTH raw asynchronous inputs
// Register map (word addresses):
//  0 data         debounced input levels (read-only)
//  1 reserved     reads 0
//  2 irq_mask     read/write
//  3 edge_capture sticky edge flags, write-1-to-clear
// irq = |(edge_capture & irq_mask)
module nios_practica_buttons_in
  import nios_practica_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nios_practica_buttons_in_if.slave bus,
  input  logic [WIDTH-1:0]      in_port
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic             wr_en;
  logic             unused_wdata;

  // Only bits [WIDTH-1:0] of writedata carry information.
  assign unused_wdata = ^bus.writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_practica_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL[i])
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .in_bit  (in_port[i]),
      .stable  (stable[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
    assign edge_set[i] = edge_hit(rise[i], fall[i], EDGE_TYPE);
  end

  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign edge_clr = (wr_en && bus.address == PIO_ADDR_EDGE)
                    ? bus.writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && bus.address == PIO_ADDR_MASK) begin
        irq_mask <= bus.writedata[WIDTH-1:0];
      end
      // a new edge on the clearing cycle wins over the W1C
      edge_capture <= (edge_capture & ~edge_clr) | edge_set;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      PIO_ADDR_DATA: bus.readdata[WIDTH-1:0] = stable;
      PIO_ADDR_MASK: bus.readdata[WIDTH-1:0] = irq_mask;
      PIO_ADDR_EDGE: bus.readdata[WIDTH-1:0] = edge_capture;
      default:       bus.readdata = '0;
    endcase
  end

  assign bus.irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_practica_buttons_in.sv
// Bench for nios_practica_buttons_in: WIDTH=4, DEBOUNCE_CYCLES=4.
// Two instances share clock, reset and inputs: one captures falling edges,
// the other any edge. A window-based model predicts both every cycle.
module tb_nios_practica_buttons_in;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] in_port;

  int checks   = 0;
  int failures = 0;

  nios_practica_buttons_in_if bus1 ();
  nios_practica_buttons_in_if bus2 ();

  nios_practica_buttons_in #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) dut_fall (
    .clk (clk), .reset_n (reset_n), .bus (bus1), .in_port (in_port));

  nios_practica_buttons_in #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut_any (
    .clk (clk), .reset_n (reset_n), .bus (bus2), .in_port (in_port));

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // stable[i] flips when the last D synchronized samples all disagree with it.
  logic [3:0] m_hist [0:D];
  logic [3:0] m_stable, m_cap1, m_cap2, m_mask;
  logic       m_valid = 1'b0;

  always @(posedge clk) begin
    logic [3:0] flip, rise, fall, clr;
    if (!reset_n) begin
      for (int j = 0; j <= D; j++) m_hist[j] <= 4'hF;
      m_stable <= 4'hF;
      m_cap1   <= 4'h0;
      m_cap2   <= 4'h0;
      m_mask   <= 4'h0;
      m_valid  <= 1'b1;
    end else begin
      flip = 4'hF;
      for (int j = 1; j <= D; j++) flip = flip & (m_hist[j] ^ m_stable);
      rise = flip & ~m_stable;
      fall = flip &  m_stable;
      clr  = (bus1.chipselect && !bus1.write_n && bus1.address == 2'd3)
             ? bus1.writedata[3:0] : 4'h0;
      m_cap1 <= (m_cap1 & ~clr) | fall;
      m_cap2 <= (m_cap2 & ~clr) | rise | fall;
      if (bus1.chipselect && !bus1.write_n && bus1.address == 2'd2)
        m_mask <= bus1.writedata[3:0];
      m_stable  <= m_stable ^ flip;
      m_hist[0] <= in_port;
      for (int j = 1; j <= D; j++) m_hist[j] <= m_hist[j-1];
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] a, input logic [3:0] cap);
    case (a)
      2'd0:    return {28'd0, m_stable};
      2'd2:    return {28'd0, m_mask};
      2'd3:    return {28'd0, cap};
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp_rd_fall",  bus1.readdata, model_rd(bus1.address, m_cap1));
      chk("cmp_rd_any",   bus2.readdata, model_rd(bus2.address, m_cap2));
      chk("cmp_irq_fall", {31'd0, bus1.irq}, {31'd0, |(m_cap1 & m_mask)});
      chk("cmp_irq_any",  {31'd0, bus2.irq}, {31'd0, |(m_cap2 & m_mask)});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_bus(input logic cs, input logic wn, input logic [1:0] a,
                         input logic [31:0] d);
    bus1.chipselect = cs; bus1.write_n = wn; bus1.address = a; bus1.writedata = d;
    bus2.chipselect = cs; bus2.write_n = wn; bus2.address = a; bus2.writedata = d;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    set_bus(1'b1, 1'b0, a, d);
    tick(1);
    set_bus(1'b0, 1'b1, 2'd0, 32'd0);
  endtask

  task automatic rd(input int which, input logic [1:0] a, input logic [31:0] exp,
                    input string name);
    bus1.address = a;
    bus2.address = a;
    #1;
    chk(name, (which == 1) ? bus1.readdata : bus2.readdata, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    in_port = 4'b0000;
    set_bus(1'b0, 1'b1, 2'd0, 32'd0);

    // reset state
    tick(2);
    rd(1, 2'd0, 32'hF, "rst_data");
    rd(1, 2'd3, 32'h0, "rst_edge");
    rd(2, 2'd0, 32'hF, "rst_data_any");
    chk("rst_irq", {31'd0, bus1.irq}, 32'd0);
    reset_n = 1'b1;
    in_port = 4'hF;
    tick(2);

    // falling edge on bit 0: accepted exactly D+1 edges after first sample
    in_port = 4'hE;
    tick(5);
    rd(1, 2'd0, 32'hF, "deb_not_yet");
    tick(1);
    rd(1, 2'd0, 32'hE, "deb_accepted");
    rd(1, 2'd3, 32'h1, "fall_captured");
    rd(2, 2'd3, 32'h1, "fall_captured_any");
    chk("irq_masked", {31'd0, bus1.irq}, 32'd0);
    chk("model_stable_e", {28'd0, m_stable}, 32'hE);
    wr(2'd2, 32'h1);
    rd(1, 2'd2, 32'h1, "mask_rd");
    chk("irq_unmasked", {31'd0, bus1.irq}, 32'd1);

    // 3-cycle glitch on bit 1 is rejected
    in_port = 4'b1100;
    tick(3);
    in_port = 4'b1110;
    tick(8);
    rd(1, 2'd0, 32'hE, "glitch_data");
    rd(1, 2'd3, 32'h1, "glitch_edge");

    // W1C, then W1C on the same edge as a new capture
    wr(2'd3, 32'h1);
    rd(1, 2'd3, 32'h0, "w1c_clear");
    chk("w1c_irq", {31'd0, bus1.irq}, 32'd0);
    in_port = 4'hF;
    tick(8);
    rd(1, 2'd0, 32'hF, "rise_data");
    rd(1, 2'd3, 32'h0, "rise_not_fall");
    rd(2, 2'd3, 32'h1, "rise_any");
    in_port = 4'hE;
    tick(5);
    set_bus(1'b1, 1'b0, 2'd3, 32'h1);
    tick(1);
    set_bus(1'b0, 1'b1, 2'd0, 32'd0);
    rd(1, 2'd0, 32'hE, "coinc_data");
    rd(1, 2'd3, 32'h1, "set_wins");
    rd(2, 2'd3, 32'h1, "set_wins_any");
    chk("set_wins_irq", {31'd0, bus1.irq}, 32'd1);
    chk("model_cap1", {28'd0, m_cap1}, 32'h1);

    // rising edge on bit 2: fall-type ignores it, any-type captures it
    in_port = 4'b1010;
    tick(8);
    rd(1, 2'd0, 32'hA, "b2_low");
    wr(2'd3, 32'hF);
    rd(1, 2'd3, 32'h0, "clr_all");
    in_port = 4'hE;
    tick(8);
    rd(1, 2'd0, 32'hE, "b2_high");
    rd(1, 2'd3, 32'h0, "b2_rise_fall_type");
    rd(2, 2'd3, 32'h4, "b2_rise_any_type");
    rd(1, 2'd1, 32'h0, "rsvd_zero");
    chk("model_cap2", {28'd0, m_cap2}, 32'h4);

    // reset in the middle of a debounce run
    in_port = 4'b1100;
    tick(4);
    reset_n = 1'b0;
    in_port = 4'hF;
    tick(1);
    rd(1, 2'd0, 32'hF, "midrst_data");
    rd(1, 2'd2, 32'h0, "midrst_mask");
    rd(1, 2'd3, 32'h0, "midrst_edge");
    reset_n = 1'b1;
    tick(10);
    rd(1, 2'd0, 32'hF, "post_rst_data");
    rd(1, 2'd3, 32'h0, "post_rst_edge");
    rd(2, 2'd3, 32'h0, "post_rst_edge_any");
    chk("post_rst_irq", {31'd0, bus1.irq}, 32'd0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
